remote_cmd_seq: RTL and testbench
=================================

# remote_cmd_seq

Synthesizable command sequencer that replays a programmed list of 16-bit Knight commands into the `RemoteComm` handshake (`cmd`/`send_cmd`/`cmd_sent`) and checks each 8-bit response against an expected acknowledge within a per-phase timeout. It sits beside `RemoteComm` in bench and FPGA-demo top levels, replacing hand-written send/wait/verify sequences. It generalises that flow with:
- parametrised queue depth and widths;
- timeout detection on both the send phase and the response phase;
- pass/fail accounting;
- a selectable stop-on-error mode.

## Interface
Parameters:
- DEPTH, 8 — command queue entries (power of two, ≥2)
- CMD_W, 16 — command width
- RESP_W, 8 — response width
- TIMEOUT_CLKS, 1000000 — max clocks per wait phase
- EXP_RESP, 8'hA5 — expected acknowledge (COMM_COMPLETE)

Ports:
- clk in 1 — system clock
- rst_n in 1 — asynchronous active-low reset
- wr_en in 1 — push wr_cmd into queue
- wr_cmd in CMD_W — command to queue
- full out 1 — queue full
- start in 1 — begin replay (sampled in IDLE only)
- stop_on_err in 1 — 1: halt at first error; 0: log error and continue
- cmd out CMD_W — command to RemoteComm
- send_cmd out 1 — one-cycle send strobe
- cmd_sent in 1 — RemoteComm transmit complete
- resp in RESP_W — received response
- resp_rdy in 1 — response valid
- clr_rx_rdy out 1 — one-cycle response clear
- busy out 1 — replay in progress
- done out 1 — replay finished (sticky until next start)
- err_timeout out 1 — sticky timeout flag
- err_resp out 1 — sticky mismatch flag
- fail_idx out $clog2(DEPTH) — index of first failing command
- pass_cnt out $clog2(DEPTH+1) — commands acknowledged correctly

## Operation
- Queue: circular buffer, write and read pointers of $clog2(DEPTH)+1 bits with wrap. wr_en while full is ignored. Writes are accepted while busy. Simultaneous push and pop keep the count unchanged.
- States: IDLE, LOAD, SEND, WAIT_SENT, WAIT_RESP, CHECK, DONE.
- IDLE: on start, clear all flags, pass_cnt and the index counter.
  - Queue empty: go to DONE.
  - Otherwise: go to LOAD.
- LOAD: pop the head into the cmd register, then go to SEND.
- SEND: assert send_cmd for one cycle and clear the timer, then go to WAIT_SENT.
- WAIT_SENT: on cmd_sent, clear the timer and go to WAIT_RESP. If the timer reaches TIMEOUT_CLKS-1, take the error path with err_timeout.
- WAIT_RESP: on resp_rdy, go to CHECK. If the timer reaches TIMEOUT_CLKS-1, take the error path with err_timeout.
- CHECK: pulse clr_rx_rdy.
  - resp==EXP_RESP: increment pass_cnt.
  - Otherwise: take the error path with err_resp.
- After CHECK, or after an error that does not stop the replay:
  - Queue non-empty: increment the index and go to LOAD.
  - Queue empty: go to DONE.
- Error path: set the flag. On the first error only, capture fail_idx = current index. If stop_on_err=1, go to DONE; otherwise continue as above. A timeout does not pulse clr_rx_rdy.
- DONE: done=1. On start, behave as IDLE does.
- Timer: saturating, $clog2(TIMEOUT_CLKS) bits, counts only in WAIT_SENT and WAIT_RESP.
- resp_rdy arriving during WAIT_SENT is ignored until WAIT_RESP is entered.

## Timing
- Reset values:
  - cmd=0, send_cmd=0, clr_rx_rdy=0
  - busy=0, done=0, err_timeout=0, err_resp=0, fail_idx=0, pass_cnt=0
  - queue empty, state IDLE
- Reset asserted mid-replay aborts immediately to the values above. The queue contents are discarded.
- start→send_cmd: 2 cycles (IDLE→LOAD→SEND). send_cmd is high during the SEND cycle, and cmd is stable from LOAD onward.
- cmd_sent high in cycle N → WAIT_RESP in N+1.
- resp_rdy in cycle M → clr_rx_rdy and pass_cnt update in M+1 → next LOAD in M+2.
- busy=1 in every state except IDLE and DONE.
- Timeout fires when the timer reaches TIMEOUT_CLKS-1, i.e. TIMEOUT_CLKS cycles after entering the wait state.
- full is combinational from the pointers and updates the cycle after a push or pop.

## Structure
- The shared package knight_pkg holds:
  - the seq_state_t enum;
  - COMM_COMPLETE=8'hA5;
  - CALIBRATE and the move-command constants used to program the queue.
- Sub-module cmd_fifo (parameters DEPTH, W; ports push, pop, din, dout, full, empty) holds the queue. The FSM, timer and counters stay in remote_cmd_seq.

## Test plan
- Queue CALIBRATE (16'h2000) and one move. The responder acks with 8'hA5 after 50 clks. Required: send_cmd twice; done=1, pass_cnt=2, no error flags.
- Second response is 8'h5A, stop_on_err=1, 4 commands queued. Required: err_resp=1, fail_idx=1, pass_cnt=1, done=1; the third command is never sent.
- Same as above with stop_on_err=0. Required: all 4 commands sent, pass_cnt=3, fail_idx=1.
- Responder never raises resp_rdy, TIMEOUT_CLKS=100. Required: err_timeout=1 exactly 100 clks after entering WAIT_RESP, and no clr_rx_rdy pulse.
- Push DEPTH+1 commands while idle. Required: full=1 after DEPTH pushes, the extra push is dropped, and exactly DEPTH commands replay.
- Deassert rst_n during WAIT_RESP. Required: all outputs at reset values the same cycle; a later start with an empty queue gives done=1 on the next cycle.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared definitions for the Knight remote-command sequencer: FSM encoding,
// acknowledge code and the command words used to program the replay queue.
package knight_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_SEND      = 3'd2,
      ST_WAIT_SENT = 3'd3,
      ST_WAIT_RESP = 3'd4,
      ST_CHECK     = 3'd5,
      ST_DONE      = 3'd6
   } seq_state_t;

   localparam logic [7:0]  COMM_COMPLETE = 8'hA5;

   localparam logic [15:0] CALIBRATE     = 16'h2000;
   localparam logic [15:0] MOVE_NORTH    = 16'h4001;
   localparam logic [15:0] MOVE_EAST     = 16'h4102;
   localparam logic [15:0] MOVE_SOUTH    = 16'h4203;
   localparam logic [15:0] MOVE_WEST     = 16'h4304;

   // Replay is in progress in every state other than the two resting states.
   function automatic logic state_busy(input seq_state_t s);
      return (s != ST_IDLE) && (s != ST_DONE);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue with wrap-bit pointers; pushes while full and pops
// while empty are dropped.
module cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push_s;
   logic         do_pop_s;

   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign dout_o    = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance
   always_comb begin
      wr_ptr_d = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
   end

   // Pointer registers; reset empties the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array, no reset needed since the pointers gate visibility
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din_i;
      end
   end

endmodule

// File: rtl/remote_cmd_seq.sv
// Replays queued Knight commands through the RemoteComm send/ack handshake,
// timing out each wait phase and tallying acknowledged commands.
module remote_cmd_seq
   import knight_pkg::*;
#(
   parameter int                DEPTH        = 8,
   parameter int                CMD_W        = 16,
   parameter int                RESP_W       = 8,
   parameter int                TIMEOUT_CLKS = 1000000,
   parameter logic [RESP_W-1:0] EXP_RESP     = COMM_COMPLETE
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en_i,
   input  logic [CMD_W-1:0]           wr_cmd_i,
   output logic                       full_o,
   input  logic                       start_i,
   input  logic                       stop_on_err_i,
   output logic [CMD_W-1:0]           cmd_o,
   output logic                       send_cmd_o,
   input  logic                       cmd_sent_i,
   input  logic [RESP_W-1:0]          resp_i,
   input  logic                       resp_rdy_i,
   output logic                       clr_rx_rdy_o,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_timeout_o,
   output logic                       err_resp_o,
   output logic [$clog2(DEPTH)-1:0]   fail_idx_o,
   output logic [$clog2(DEPTH+1)-1:0] pass_cnt_o
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT_CLKS - 1);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [CW-1:0] PASS_ONE = CW'(1);
   localparam logic [CW-1:0] PASS_MAX = CW'(DEPTH);

   seq_state_t        state_q, state_d;
   logic [CMD_W-1:0]  cmd_q, cmd_d;
   logic              send_cmd_q, send_cmd_d;
   logic              clr_rx_rdy_q, clr_rx_rdy_d;
   logic              busy_q, done_q;
   logic              err_timeout_q, err_timeout_d;
   logic              err_resp_q, err_resp_d;
   logic [IW-1:0]     fail_idx_q, fail_idx_d;
   logic [CW-1:0]     pass_cnt_q, pass_cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [RESP_W-1:0] resp_q, resp_d;

   logic              pop_s;
   logic [CMD_W-1:0]  fifo_dout_s;
   logic              fifo_empty_s;
   logic              first_err_s;
   logic              err_cont_s;
   logic [TW-1:0]     timer_inc_s;

   cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wr_en_i),
      .pop_i   (pop_s),
      .din_i   (wr_cmd_i),
      .dout_o  (fifo_dout_s),
      .full_o  (full_o),
      .empty_o (fifo_empty_s)
   );

   // Only the first error of a replay records its index; err_cont_s says an
   // error may move on to the next queued command.
   assign first_err_s = !err_timeout_q && !err_resp_q;
   assign err_cont_s  = !stop_on_err_i && !fifo_empty_s;
   assign timer_inc_s = (timer_q == T_LAST) ? timer_q : (timer_q + T_ONE);

   // Sequencer next-state logic
   always_comb begin
      state_d       = state_q;
      cmd_d         = cmd_q;
      send_cmd_d    = 1'b0;
      clr_rx_rdy_d  = 1'b0;
      err_timeout_d = err_timeout_q;
      err_resp_d    = err_resp_q;
      fail_idx_d    = fail_idx_q;
      pass_cnt_d    = pass_cnt_q;
      idx_d         = idx_q;
      timer_d       = timer_q;
      resp_d        = resp_q;
      pop_s         = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               err_timeout_d = 1'b0;
               err_resp_d    = 1'b0;
               fail_idx_d    = '0;
               pass_cnt_d    = '0;
               idx_d         = '0;
               state_d       = fifo_empty_s ? ST_DONE : ST_LOAD;
            end else begin
               state_d = state_q;
            end
         end
         ST_LOAD: begin
            pop_s      = 1'b1;
            cmd_d      = fifo_dout_s;
            send_cmd_d = 1'b1;
            state_d    = ST_SEND;
         end
         ST_SEND: begin
            timer_d = '0;
            state_d = ST_WAIT_SENT;
         end
         ST_WAIT_SENT, ST_WAIT_RESP: begin
            if ((state_q == ST_WAIT_SENT) && cmd_sent_i) begin
               timer_d = '0;
               state_d = ST_WAIT_RESP;
            end else if ((state_q == ST_WAIT_RESP) && resp_rdy_i) begin
               resp_d       = resp_i;
               clr_rx_rdy_d = 1'b1;
               state_d      = ST_CHECK;
            end else if (timer_q == T_LAST) begin
               err_timeout_d = 1'b1;
               fail_idx_d    = first_err_s ? idx_q : fail_idx_q;
               idx_d         = err_cont_s ? (idx_q + IDX_ONE) : idx_q;
               state_d       = err_cont_s ? ST_LOAD : ST_DONE;
            end else begin
               timer_d = timer_inc_s;
            end
         end
         ST_CHECK: begin
            if (resp_q == EXP_RESP) begin
               pass_cnt_d = (pass_cnt_q == PASS_MAX) ? pass_cnt_q : (pass_cnt_q + PASS_ONE);
               idx_d      = fifo_empty_s ? idx_q : (idx_q + IDX_ONE);
               state_d    = fifo_empty_s ? ST_DONE : ST_LOAD;
            end else begin
               err_resp_d = 1'b1;
               fail_idx_d = first_err_s ? idx_q : fail_idx_q;
               idx_d      = err_cont_s ? (idx_q + IDX_ONE) : idx_q;
               state_d    = err_cont_s ? ST_LOAD : ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         cmd_q         <= '0;
         send_cmd_q    <= 1'b0;
         clr_rx_rdy_q  <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_timeout_q <= 1'b0;
         err_resp_q    <= 1'b0;
         fail_idx_q    <= '0;
         pass_cnt_q    <= '0;
         idx_q         <= '0;
         timer_q       <= '0;
         resp_q        <= '0;
      end else begin
         state_q       <= state_d;
         cmd_q         <= cmd_d;
         send_cmd_q    <= send_cmd_d;
         clr_rx_rdy_q  <= clr_rx_rdy_d;
         busy_q        <= state_busy(state_d);
         done_q        <= (state_d == ST_DONE);
         err_timeout_q <= err_timeout_d;
         err_resp_q    <= err_resp_d;
         fail_idx_q    <= fail_idx_d;
         pass_cnt_q    <= pass_cnt_d;
         idx_q         <= idx_d;
         timer_q       <= timer_d;
         resp_q        <= resp_d;
      end
   end

   assign cmd_o         = cmd_q;
   assign send_cmd_o    = send_cmd_q;
   assign clr_rx_rdy_o  = clr_rx_rdy_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign err_timeout_o = err_timeout_q;
   assign err_resp_o    = err_resp_q;
   assign fail_idx_o    = fail_idx_q;
   assign pass_cnt_o    = pass_cnt_q;

endmodule

// File: tb/tb_remote_cmd_seq.sv
// Scoreboard bench for remote_cmd_seq: queued commands are expected back on
// send_cmd in order, with a behavioural RemoteComm responder.
module tb_remote_cmd_seq;
   import knight_pkg::*;

   localparam int DEPTH = 8;
   localparam int TO    = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [15:0] wr_cmd;
   logic        full;
   logic        start;
   logic        stop_on_err;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent;
   logic [7:0]  resp;
   logic        resp_rdy;
   logic        clr_rx_rdy;
   logic        busy;
   logic        done;
   logic        err_timeout;
   logic        err_resp;
   logic [2:0]  fail_idx;
   logic [3:0]  pass_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   int          send_cnt;
   int          clr_cnt;
   int          rsp_n   = 0;
   int          rsp_base;
   int          t_sent  = 0;
   bit          never_resp;
   logic [7:0]  resp_tbl [8];
   logic [15:0] exp_q [$];

   remote_cmd_seq #(
      .DEPTH        (DEPTH),
      .CMD_W        (16),
      .RESP_W       (8),
      .TIMEOUT_CLKS (TO),
      .EXP_RESP     (COMM_COMPLETE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (wr_en),
      .wr_cmd_i      (wr_cmd),
      .full_o        (full),
      .start_i       (start),
      .stop_on_err_i (stop_on_err),
      .cmd_o         (cmd),
      .send_cmd_o    (send_cmd),
      .cmd_sent_i    (cmd_sent),
      .resp_i        (resp),
      .resp_rdy_i    (resp_rdy),
      .clr_rx_rdy_o  (clr_rx_rdy),
      .busy_o        (busy),
      .done_o        (done),
      .err_timeout_o (err_timeout),
      .err_resp_o    (err_resp),
      .fail_idx_o    (fail_idx),
      .pass_cnt_o    (pass_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [15:0] c, input bit accepted);
      wr_cmd = c;
      wr_en  = 1'b1;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      if (accepted) exp_q.push_back(c);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
   endtask

   // Start a replay and check the two-cycle start-to-send latency.
   task automatic run(input bit stop);
      stop_on_err = stop;
      rsp_base    = rsp_n;
      start       = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("lat1_busy", 32'(busy), 32'd1);
      chk("lat1_send", 32'(send_cmd), 32'd0);
      @(posedge clk);
      #1;
      chk("lat2_send", 32'(send_cmd), 32'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 3000; i++) begin
         if (done) break;
         @(posedge clk);
         #1;
      end
      chk("done", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
   endtask

   // RemoteComm model: cmd_sent 5 clks after send, response ~50 clks later,
   // held until clr_rx_rdy.
   initial begin : responder
      cmd_sent = 1'b0;
      resp_rdy = 1'b0;
      resp     = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && send_cmd) begin
            repeat (5) @(posedge clk);
            #1;
            cmd_sent = 1'b1;
            t_sent   = cyc;
            @(posedge clk);
            #1;
            cmd_sent = 1'b0;
            repeat (48) @(posedge clk);
            #1;
            if (!never_resp) begin
               resp     = resp_tbl[(rsp_n - rsp_base) % 8];
               resp_rdy = 1'b1;
               for (int i = 0; i < 200; i++) begin
                  @(posedge clk);
                  #1;
                  if (clr_rx_rdy || !rst_n) break;
               end
               resp_rdy = 1'b0;
            end
            rsp_n++;
         end
      end
   end

   // Scoreboard: every send_cmd must carry the oldest accepted command.
   initial begin : monitor
      logic [15:0] exp_cmd;
      send_cnt = 0;
      clr_cnt  = 0;
      forever begin
         @(negedge clk);
         if (rst_n && send_cmd) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               exp_cmd = exp_q.pop_front();
               chk("sb_cmd", 32'(cmd), 32'(exp_cmd));
            end
            send_cnt++;
         end
         if (rst_n && clr_rx_rdy) clr_cnt++;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      int s0;
      int c0;
      int t_err;
      rst_n       = 1'b0;
      wr_en       = 1'b0;
      wr_cmd      = 16'h0000;
      start       = 1'b0;
      stop_on_err = 1'b0;
      never_resp  = 1'b0;
      rsp_base    = 0;
      for (int i = 0; i < 8; i++) resp_tbl[i] = COMM_COMPLETE;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd", 32'(cmd), 32'd0);
      chk("rst_send", 32'(send_cmd), 32'd0);
      chk("rst_clr", 32'(clr_rx_rdy), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_flags", {30'd0, err_timeout, err_resp}, 32'd0);
      chk("rst_cnts", {25'd0, fail_idx, pass_cnt}, 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Calibrate plus one move, all acknowledged
      push(CALIBRATE, 1'b1);
      push(MOVE_NORTH, 1'b1);
      s0 = send_cnt; c0 = clr_cnt;
      run(1'b0);
      wait_done();
      chk("t1_sends", 32'(send_cnt - s0), 32'd2);
      chk("t1_clrs", 32'(clr_cnt - c0), 32'd2);
      chk("t1_pass", 32'(pass_cnt), 32'd2);
      chk("t1_flags", {30'd0, err_timeout, err_resp}, 32'd0);

      // Bad second response, stop on error
      apply_reset();
      resp_tbl[1] = 8'h5A;
      push(CALIBRATE, 1'b1);
      push(MOVE_EAST, 1'b1);
      push(MOVE_SOUTH, 1'b1);
      push(MOVE_WEST, 1'b1);
      s0 = send_cnt;
      run(1'b1);
      wait_done();
      repeat (100) @(posedge clk);
      #1;
      chk("t2_sends", 32'(send_cnt - s0), 32'd2);
      chk("t2_err_resp", 32'(err_resp), 32'd1);
      chk("t2_err_to", 32'(err_timeout), 32'd0);
      chk("t2_fail_idx", 32'(fail_idx), 32'd1);
      chk("t2_pass", 32'(pass_cnt), 32'd1);
      chk("t2_left", 32'(exp_q.size()), 32'd2);

      // Bad second response, continue past error
      apply_reset();
      push(CALIBRATE, 1'b1);
      push(MOVE_EAST, 1'b1);
      push(MOVE_SOUTH, 1'b1);
      push(MOVE_WEST, 1'b1);
      s0 = send_cnt; c0 = clr_cnt;
      run(1'b0);
      wait_done();
      chk("t3_sends", 32'(send_cnt - s0), 32'd4);
      chk("t3_clrs", 32'(clr_cnt - c0), 32'd4);
      chk("t3_err_resp", 32'(err_resp), 32'd1);
      chk("t3_fail_idx", 32'(fail_idx), 32'd1);
      chk("t3_pass", 32'(pass_cnt), 32'd3);
      resp_tbl[1] = COMM_COMPLETE;

      // Overfill the queue while idle
      apply_reset();
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("t5_not_full", 32'(full), 32'd0);
         push(16'h4000 | 16'(i), 1'b1);
      end
      chk("t5_full", 32'(full), 32'd1);
      push(16'hFFFF, 1'b0);
      chk("t5_full_drop", 32'(full), 32'd1);
      s0 = send_cnt;
      run(1'b0);
      wait_done();
      chk("t5_sends", 32'(send_cnt - s0), 32'd8);
      chk("t5_pass", 32'(pass_cnt), 32'd8);
      chk("t5_full_end", 32'(full), 32'd0);

      // Response never arrives
      apply_reset();
      never_resp = 1'b1;
      push(MOVE_WEST, 1'b1);
      c0 = clr_cnt;
      run(1'b1);
      t_err = -1;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         if (err_timeout) begin
            t_err = cyc;
            break;
         end
      end
      chk("t4_err_to", 32'(err_timeout), 32'd1);
      chk("t4_latency", 32'(t_err - (t_sent + 1)), 32'd100);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_err_resp", 32'(err_resp), 32'd0);
      chk("t4_fail_idx", 32'(fail_idx), 32'd0);
      chk("t4_clrs", 32'(clr_cnt - c0), 32'd0);

      // Reset in the middle of WAIT_RESP
      apply_reset();
      push(MOVE_NORTH, 1'b1);
      run(1'b1);
      repeat (20) @(posedge clk);
      #1;
      chk("t6_pre_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_cmd", 32'(cmd), 32'd0);
      chk("t6_strobes", {30'd0, send_cmd, clr_rx_rdy}, 32'd0);
      chk("t6_busy_done", {30'd0, busy, done}, 32'd0);
      chk("t6_cnts", {25'd0, fail_idx, pass_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t6_empty_done", 32'(done), 32'd1);
      chk("t6_empty_busy", 32'(busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
